// File: rtl/barrel_unshift_seq_if.sv
// rtl/barrel_unshift_seq_if.sv - handshake bundle for the sequential unshifter
//
// Purpose: groups the operation request, result and status signals of
// barrel_unshift_seq so producer/consumer and block connect through one port.
//   master : drives in_valid/in_data/in_amt/in_mode/out_ready, observes the rest
//   slave  : the unshifter itself
// Signals:
//   in_valid/in_ready     request handshake
//   in_data[WIDTH]        operand word
//   in_amt[SHW]           shift amount
//   in_mode[2]            00 ror, 01 lsr, 10 asr, 11 rol
//   out_valid/out_ready   result handshake
//   out_data[WIDTH]       registered result
//   busy                  operation in SHIFT or DONE
interface barrel_unshift_seq_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/barrel_unshift_seq.sv
// rtl/barrel_unshift_seq.sv - one-bit-per-clock right/left shifter with valid/ready
//
// Purpose: inverse datapath of the single-cycle barrel shifter. Rotates right,
// shifts right logically or arithmetically, or rotates left, one bit per edge.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  barrel_unshift_seq_if.slave (request, result and busy status)
module barrel_unshift_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    barrel_unshift_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_out_data;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [SHW-1:0]   w_cnt_nxt;
    logic [1:0]       w_mode_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_step;

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = {v[0], v[WIDTH-1:1]};
            2'b01:   r = {1'b0, v[WIDTH-1:1]};
            2'b10:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {v[WIDTH-2:0], v[WIDTH-1]};
        endcase
        return r;
    endfunction

    assign w_first = shift1(bus.in_data, bus.in_mode);
    assign w_step  = shift1(r_shreg, r_mode);

    // The accept edge already performs the first shift, so an amount of k
    // reaches DONE after exactly k edges and the counter holds the shifts
    // still outstanding after the current register value.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_out_nxt   = r_out_data;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_mode_nxt = bus.in_mode;
                    if (bus.in_amt == '0) begin
                        w_shreg_nxt = bus.in_data;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = bus.in_data;
                        w_state_nxt = DONE;
                    end else begin
                        w_shreg_nxt = w_first;
                        w_cnt_nxt   = bus.in_amt - SHW'(1);
                        if (bus.in_amt == SHW'(1)) begin
                            w_out_nxt   = w_first;
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                w_shreg_nxt = w_step;
                w_cnt_nxt   = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_out_nxt   = w_step;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_mode     <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mode     <= w_mode_nxt;
            r_out_data <= w_out_nxt;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == SHIFT) || (r_state == DONE);
    assign bus.out_data  = r_out_data;

endmodule
